// File: rtl/block_assembler_if.sv
// -----------------------------------------------------------------------------
// block_assembler_if
//
// Purpose:
//   Groups the element input stream and the block output stream of
//   block_assembler into one bundle. Both directions use valid/ready.
//
// Signals:
//   in_valid   producer -> assembler  in_data carries an element this cycle
//   in_data    producer -> assembler  ELEM_W-bit element
//   in_last    producer -> assembler  element ends the block early (with in_valid)
//   in_ready   assembler -> producer  element accepted this cycle
//   out_valid  assembler -> consumer  out_data holds a complete block
//   out_ready  consumer -> assembler  block taken this cycle
//   out_data   assembler -> consumer  block, first-received element in the MSBs
//   out_count  assembler -> consumer  number of real (non-pad) elements
//
// Modports:
//   master  environment side (producer + consumer)
//   slave   assembler side
// -----------------------------------------------------------------------------
interface block_assembler_if #(
   parameter int ELEM_W    = 8,
   parameter int NUM_ELEMS = 44,
   parameter int COUNT_W   = $clog2(NUM_ELEMS + 1)
) ();

   logic                        in_valid;
   logic [ELEM_W-1:0]           in_data;
   logic                        in_last;
   logic                        in_ready;
   logic                        out_valid;
   logic                        out_ready;
   logic [ELEM_W*NUM_ELEMS-1:0] out_data;
   logic [COUNT_W-1:0]          out_count;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_count
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_count
   );

endinterface

// File: rtl/block_assembler.sv
// -----------------------------------------------------------------------------
// block_assembler
//
// Purpose:
//   Collects ELEM_W-bit elements into a NUM_ELEMS-element block and hands the
//   block to a downstream consumer over valid/ready. The first element of a
//   block lands in the MSBs. A block ends when NUM_ELEMS elements have arrived
//   or when an element carries in_last; unused trailing elements read as zero.
//
// Build option:
//   BLOCK_ASM_DOUBLE_BUF_EN  when defined, a second fill buffer lets a new
//                            block be collected while the previous one waits
//                            for the consumer. Blocks leave in arrival order.
//                            When undefined, one buffer alternates between
//                            filling and holding. The port list is the same.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   block_assembler_if.slave (in_valid/in_data/in_last/in_ready,
//         out_valid/out_ready/out_data/out_count)
// -----------------------------------------------------------------------------
module block_assembler #(
   parameter int ELEM_W    = 8,
   parameter int NUM_ELEMS = 44,
   parameter int COUNT_W   = $clog2(NUM_ELEMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   block_assembler_if.slave bus
);

`ifdef BLOCK_ASM_DOUBLE_BUF_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif

   localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

   typedef logic [ELEM_W-1:0]            elem_t;
   // Element k of a block is stored at packed index NUM_ELEMS-1-k so that the
   // first-received element occupies the most significant bits.
   typedef elem_t [NUM_ELEMS-1:0]        block_t;

   // Each buffer is either being filled or holding a completed block.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } buf_state_e;

   // Buffer storage and per-buffer bookkeeping
   block_t             buf_q   [NBUF];
   block_t             buf_d   [NBUF];
   buf_state_e         state_q [NBUF];
   buf_state_e         state_d [NBUF];
   logic [COUNT_W-1:0] bcnt_q  [NBUF];
   logic [COUNT_W-1:0] bcnt_d  [NBUF];

   // Elements written so far into the buffer being filled
   logic [COUNT_W-1:0] cnt_q;
   logic [COUNT_W-1:0] cnt_d;

   // wr points at the buffer being filled, rd at the oldest held block. With a
   // single buffer both stay at zero.
   logic               wr_q;
   logic               wr_d;
   logic               rd_q;
   logic               rd_d;

   logic               out_valid;
   logic               in_ready;
   logic               pop;
   logic               accept;
   logic               block_done;
   logic [IDX_W-1:0]   wr_idx;

   function automatic logic next_ptr(input logic p);
      return (NBUF == 2) ? ~p : 1'b0;
   endfunction

   assign out_valid = (state_q[rd_q] == ST_HOLD);

   // ---------------------------------------------------------------------------
   // Handshake and next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      buf_d      = buf_q;
      state_d    = state_q;
      bcnt_d     = bcnt_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      block_done = 1'b0;

      pop = out_valid & bus.out_ready;

      // The fill buffer can take an element unless it is itself holding a
      // block. It only holds when every buffer is full, and then wr and rd
      // name the same (oldest) buffer, so a pop this cycle frees it in time
      // for the incoming element.
      in_ready = ~rst & ((state_q[wr_q] == ST_FILL) | (pop & (wr_q == rd_q)));
      accept   = bus.in_valid & in_ready;

      wr_idx = IDX_W'(NUM_ELEMS - 1) - IDX_W'(cnt_q);

      // A popped buffer is cleared at once so the next block starting in it
      // sees zero padding rather than stale elements.
      if (pop) begin
         buf_d[rd_q]   = '0;
         state_d[rd_q] = ST_FILL;
         rd_d          = next_ptr(rd_q);
      end

      // Applied after the pop so an element accepted into the just-popped
      // buffer lands on top of the cleared contents.
      if (accept) begin
         buf_d[wr_q][wr_idx] = bus.in_data;
         block_done = bus.in_last | (cnt_q == COUNT_W'(NUM_ELEMS - 1));
         if (block_done) begin
            state_d[wr_q] = ST_HOLD;
            bcnt_d[wr_q]  = cnt_q + COUNT_W'(1);
            cnt_d         = '0;
            wr_d          = next_ptr(wr_q);
         end else begin
            cnt_d = cnt_q + COUNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the block buffers are reset, unlike a typical RAM, because
         // out_data must read zero straight out of reset and padding relies on
         // a cleared buffer.
         for (int b = 0; b < NBUF; b++) begin
            buf_q[b]   <= '0;
            state_q[b] <= ST_FILL;
            bcnt_q[b]  <= '0;
         end
         cnt_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // values computed before this edge, independent of statement order.
         buf_q   <= buf_d;
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = buf_q[rd_q];
   assign bus.out_count = bcnt_q[rd_q];

endmodule

// File: tb/tb_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_block_assembler
//
// Directed and randomized stimulus for block_assembler (44 x 8-bit) plus a
// second instance at ELEM_W=32, NUM_ELEMS=4. Expected values come from a
// queue-based model: elements of the block in progress are collected in a
// queue, completed blocks wait in a FIFO whose capacity is one (single
// buffer) or two (BLOCK_ASM_DOUBLE_BUF_EN).
// -----------------------------------------------------------------------------
module tb_block_assembler;

   localparam int ELEM_W    = 8;
   localparam int NUM_ELEMS = 44;
   localparam int COUNT_W   = $clog2(NUM_ELEMS + 1);
   localparam int BLK_W     = ELEM_W * NUM_ELEMS;

   localparam int E4_W    = 32;
   localparam int E4_N    = 4;
   localparam int E4_CW   = $clog2(E4_N + 1);
   localparam int E4_BLKW = E4_W * E4_N;

`ifdef BLOCK_ASM_DOUBLE_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   block_assembler_if #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS), .COUNT_W(COUNT_W)) bus ();
   block_assembler #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS), .COUNT_W(COUNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   block_assembler_if #(.ELEM_W(E4_W), .NUM_ELEMS(E4_N), .COUNT_W(E4_CW)) bus4 ();
   block_assembler #(.ELEM_W(E4_W), .NUM_ELEMS(E4_N), .COUNT_W(E4_CW)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [BLK_W-1:0] data;
      int               cnt;
   } blk_t;

   blk_t              held_q [$];
   logic [ELEM_W-1:0] cur_q  [$];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [BLK_W-1:0] obs,
                        input logic [BLK_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      held_q.delete();
      cur_q.delete();
   endtask

   // Packs the elements of the block in progress, first element at the top,
   // zero padding below the last real element.
   task automatic model_close_block();
      blk_t b;
      b.data = '0;
      b.cnt  = cur_q.size();
      foreach (cur_q[k]) b.data = (b.data << ELEM_W) | BLK_W'(cur_q[k]);
      b.data = b.data << (ELEM_W * (NUM_ELEMS - b.cnt));
      held_q.push_back(b);
      cur_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, BLK_W'(bus.out_valid), BLK_W'(held_q.size() > 0));
      if (held_q.size() > 0) begin
         check({tag, ".out_data"},  bus.out_data,          held_q[0].data);
         check({tag, ".out_count"}, BLK_W'(bus.out_count), BLK_W'(held_q[0].cnt));
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".in_ready"},  BLK_W'(bus.in_ready),  '0);
      check({tag, ".out_valid"}, BLK_W'(bus.out_valid), '0);
      check({tag, ".out_data"},  bus.out_data,          '0);
      check({tag, ".out_count"}, BLK_W'(bus.out_count), '0);
   endtask

   // One clock cycle on the main instance: called at a falling edge, drives
   // inputs, checks in_ready, advances the model at the rising edge and checks
   // outputs at the next falling edge.
   task automatic drive(input string tag, input logic v, input logic [ELEM_W-1:0] d,
                        input logic l, input logic r);
      logic exp_rdy;
      logic do_pop;
      logic do_acc;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = r;
      #1;
      exp_rdy = (held_q.size() < CAP) || r;
      check({tag, ".in_ready"}, BLK_W'(bus.in_ready), BLK_W'(exp_rdy));
      do_pop = (held_q.size() > 0) && r;
      do_acc = v && exp_rdy;
      @(posedge clk);
      if (do_pop) void'(held_q.pop_front());
      if (do_acc) begin
         cur_q.push_back(d);
         if (l || cur_q.size() == NUM_ELEMS) model_close_block();
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input logic r);
      drive(tag, 1'b0, ELEM_W'($urandom), 1'($urandom), r);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [E4_BLKW-1:0] exp4;

      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_data   = '0;
      bus4.in_last   = 1'b0;
      bus4.out_ready = 1'b0;
      model_reset();

      // Reset values while rst is held
      #1;
      check_reset_values("por");
      @(negedge clk);
      rst = 1'b0;

      // Full block 0x00..0x2B, consumer always ready
      for (int i = 0; i < NUM_ELEMS; i++) drive("full", 1'b1, ELEM_W'(i), 1'b0, 1'b1);
      check("full.first_elem", BLK_W'(bus.out_data[BLK_W-1 -: ELEM_W]), BLK_W'(8'h00));
      check("full.last_elem",  BLK_W'(bus.out_data[ELEM_W-1:0]),        BLK_W'(8'h2B));
      check("full.count",      BLK_W'(bus.out_count),                   BLK_W'(NUM_ELEMS));
      idle("full.pop", 1'b1);

      // Early end with in_last on the third element
      drive("early", 1'b1, 8'hA1, 1'b0, 1'b1);
      drive("early", 1'b1, 8'hB2, 1'b0, 1'b1);
      drive("early", 1'b1, 8'hC3, 1'b1, 1'b1);
      check("early.head", BLK_W'(bus.out_data[BLK_W-1 -: 24]), BLK_W'(24'hA1B2C3));
      check("early.pad",  BLK_W'(bus.out_data[BLK_W-25:0]),    '0);
      check("early.count", BLK_W'(bus.out_count), BLK_W'(3));
      idle("early.pop", 1'b1);

      // Backpressure: block held for 5 cycles, then pop together with 0x55
      for (int i = 0; i < NUM_ELEMS; i++) drive("bp.fill", 1'b1, ELEM_W'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle("bp.hold", 1'b0);
      drive("bp.pop55", 1'b1, 8'h55, 1'b0, 1'b1);
      for (int i = 1; i < NUM_ELEMS; i++) drive("bp.refill", 1'b1, ELEM_W'($urandom), 1'b0, 1'b1);
      check("bp.elem0", BLK_W'(bus.out_data[BLK_W-1 -: ELEM_W]), BLK_W'(8'h55));
      idle("bp.pop", 1'b1);

      // Asynchronous reset pulse between edges after 10 elements
      for (int i = 0; i < 10; i++) drive("arst.pre", 1'b1, ELEM_W'($urandom), 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("arst");
      model_reset();
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NUM_ELEMS; i++) drive("arst.post", 1'b1, ELEM_W'($urandom), 1'b0, 1'b0);
      check("arst.count", BLK_W'(bus.out_count), BLK_W'(NUM_ELEMS));
      idle("arst.pop", 1'b1);

      // Stream until every buffer is full with the consumer stalled, then pop
      for (int i = 0; i < NUM_ELEMS * CAP; i++) drive("stall.fill", 1'b1, ELEM_W'($urandom), 1'b0, 1'b0);
      drive("stall.full", 1'b1, ELEM_W'($urandom), 1'b0, 1'b0);
      check("stall.in_ready_low", BLK_W'(bus.in_ready), '0);
      idle("stall.pop1", 1'b1);
      idle("stall.pop2", 1'b1);

      // 32-bit x 4 instance, main instance left idle
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < E4_N; i++) begin
         bus4.in_valid = 1'b1;
         bus4.in_data  = E4_W'(32'h11111111 * (i + 1));
         bus4.in_last  = 1'b0;
         @(negedge clk);
      end
      bus4.in_valid = 1'b0;
      exp4 = 128'h11111111_22222222_33333333_44444444;
      check("w32.out_valid", BLK_W'(bus4.out_valid), BLK_W'(1'b1));
      check("w32.out_data",  BLK_W'(bus4.out_data),  BLK_W'(exp4));
      check("w32.out_count", BLK_W'(bus4.out_count), BLK_W'(E4_N));
      bus4.out_ready = 1'b1;
      @(negedge clk);
      check("w32.popped", BLK_W'(bus4.out_valid), '0);

      // Randomized traffic with early ends and consumer stalls
      for (int i = 0; i < 3000; i++) begin
         drive("rand", ($urandom_range(0, 3) != 0), ELEM_W'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/block_assembler.md
Name: block_assembler

Overview:
- Parametrised successor to the fixed 44-byte header shift register.
- Accumulates ELEM_W-bit elements into one NUM_ELEMS-element block, with first-received element in the MSBs.
- Presents the block to a downstream consumer (e.g. hash/midstate stage) over a valid/ready handshake.
- Adds early termination with zero padding, an element count, and an optional double-buffered mode, so filling continues while the consumer stalls.

Parameters:
- ELEM_W, 8, width of one input element in bits.
- NUM_ELEMS, 44, elements per block (>=2).
- COUNT_W, $clog2(NUM_ELEMS+1), width of the element counter and out_count.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data carries an element this cycle.
- in_data  input  ELEM_W  element.
- in_last  input  1  qualified by in_valid; this element ends the block early.
- in_ready  output  1  block accepts an element this cycle.
- out_valid  output  1  out_data holds a complete block.
- out_ready  input  1  consumer takes the block this cycle.
- out_data  output  ELEM_W*NUM_ELEMS  block; element k (k-th received, 0-based) at bits [W-1-k*ELEM_W -: ELEM_W], W=ELEM_W*NUM_ELEMS.
- out_count  output  COUNT_W  number of real (non-pad) elements in out_data, 1..NUM_ELEMS.

Behaviour:
- Reset (async assert, sync release): state FILL, count=0, out_valid=0, out_data=0, out_count=0. in_ready=0 while rst high, 1 from the first cycle after release.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Single-buffer states:
  - FILL: in_ready=1. On accept, element written at index count and count increments. If count==NUM_ELEMS-1 or in_last, the block completes: next state HOLD, out_valid=1 on the next cycle (latency 1 from the completing element), out_count = elements received.
  - HOLD: out_data and out_count stable. in_ready=out_ready (combinational pass-through).
    - Pop without accept -> FILL, count=0, block buffer cleared to zero.
    - Pop with accept -> new element at index 0, remaining elements cleared, count=1, state FILL. If in_last is also set, or NUM_ELEMS==1 is disallowed, the block completes immediately: stay HOLD with out_count=1.
- Padding: elements beyond out_count read as zero. The buffer is cleared at every block start, never left stale.
- in_last on the NUM_ELEMS-th element: ordinary full completion, out_count=NUM_ELEMS.
- out_valid never deasserts without a pop. out_data never changes while out_valid=1 and out_ready=0.
- in_valid=0: no state change. in_data/in_last are don't-care.
- Reset mid-block: partial data discarded, outputs return to reset values asynchronously.

Optional Feature:
- Macro: BLOCK_ASM_DOUBLE_BUF_EN.
- Defined: a second fill buffer is compiled in.
  - While a block is held (out_valid=1, no pop), FILL continues into the alternate buffer; in_ready=1 until the alternate buffer also completes.
  - in_ready then equals out_ready.
  - On pop, a completed alternate block is presented the next cycle (out_valid stays 1, no bubble). Otherwise out_valid drops.
  - Ordering is strictly FIFO.
- Undefined: single buffer exactly as in Behaviour. Port list is identical in both builds.

Test Plan:
- Full block, ELEM_W=8, NUM_ELEMS=44, out_ready=1: send 0x00..0x2B on consecutive cycles -> out_valid one cycle after 0x2B; out_data[351:344]=0x00, out_data[7:0]=0x2B; out_count=44; pop next cycle.
- Early end: send 0xA1,0xB2,0xC3 with in_last on 0xC3 -> out_data[351:328]=0xA1B2C3, rest 0; out_count=3.
- Backpressure: complete a block with out_ready=0 for 5 cycles -> out_data/out_count stable, in_ready=0 (single build); raise out_ready with in_valid=1, data 0x55 -> block popped, 0x55 at index 0, count=1, no element lost.
- Async reset mid-fill: after 10 elements pulse rst between edges -> out_valid=0, out_data=0 immediately; the next 44 elements form a clean block with out_count=44.
- Non-default params, ELEM_W=32, NUM_ELEMS=4: send 0x11111111..0x44444444 -> out_data=0x11111111_22222222_33333333_44444444.
- BLOCK_ASM_DOUBLE_BUF_EN: hold out_ready=0, stream 88 elements -> in_ready stays 1 through element 88 then drops; two pops return blocks in order on consecutive cycles.
